// File: rtl/core_reset_pkg.sv
// Shared types and constants for the core reset sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package core_reset_pkg;

  // Debug codes are visible on the state port, so the encoding is fixed.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    HOLD      = 3'd2,
    MEM_INIT  = 3'd3,
    RUN       = 3'd4
  } rst_state_e;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 64;
  localparam int DEF_MEM_TIMEOUT_CYCLES = 65535;

  // One counter serves every timed state, so it is sized for the largest
  // interval plus one spare bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/core_sync_bit.sv
// Multi-flop single-bit synchronizer with async clear to 0.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none (level path).
// Ports: clk, rst (async active-high), d (async input), q (synchronized).
// STAGES must be at least 2.
module core_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/core_reset_seq.sv
// Reset sequencer behind the core PLL: qualifies lock, holds resets, waits for memory init.
// Latency: outputs registered from the next state; pll_locked to outputs is SYNC_STAGES+1 cycles.
// Backpressure: none; mem_ready is a level handshake, soft_reset a one-cycle pulse.
// Ports: clk, rst (async active-high), pll_locked (async), soft_reset, mem_ready ->
//        mem_reset, core_reset, ready, mem_fault (sticky), state (debug code).
// Optional: define CORE_RESET_SEQ_LOSS_COUNT_EN to add the 8-bit saturating lock_loss_count port.
module core_reset_seq
  import core_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int MEM_TIMEOUT_CYCLES = DEF_MEM_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset,
  input  logic       mem_ready,
  output logic       mem_reset,
  output logic       core_reset,
  output logic       ready,
  output logic       mem_fault,
  output logic [2:0] state
`ifdef CORE_RESET_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES, MEM_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] MEM_LAST    = CW'(MEM_TIMEOUT_CYCLES - 1);

  logic          lock_s;
  rst_state_e    cur_st;
  rst_state_e    nxt_st;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          cnt_run;
  logic          timeout;
  logic          lock_loss;
  logic          mem_reset_d;
  logic          core_reset_d;
  logic          ready_d;

  core_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Next state, counter control and next-output decode.
  always_comb begin
    nxt_st    = cur_st;
    cnt_clr   = 1'b0;
    timeout   = 1'b0;
    lock_loss = 1'b0;
    if (cur_st != WAIT_LOCK && !lock_s) begin
      nxt_st    = WAIT_LOCK;
      lock_loss = 1'b1;
    end else if (soft_reset && (cur_st == HOLD || cur_st == MEM_INIT || cur_st == RUN)) begin
      // Explicit clear: a soft reset while already in HOLD restarts the hold.
      nxt_st  = HOLD;
      cnt_clr = 1'b1;
    end else begin
      case (cur_st)
        WAIT_LOCK: if (lock_s) nxt_st = STABLE;
        STABLE:    if (cnt == STABLE_LAST) nxt_st = HOLD;
        HOLD:      if (cnt == HOLD_LAST) nxt_st = MEM_INIT;
        MEM_INIT: begin
          if (mem_ready) begin
            nxt_st = RUN;
          end else if (cnt == MEM_LAST) begin
            nxt_st  = HOLD;
            timeout = 1'b1;
          end
        end
        RUN:       ;
        default:   nxt_st = WAIT_LOCK;
      endcase
    end
    if (nxt_st != cur_st) cnt_clr = 1'b1;

    cnt_run      = (cur_st == STABLE) || (cur_st == HOLD) || (cur_st == MEM_INIT);
    mem_reset_d  = (nxt_st == WAIT_LOCK) || (nxt_st == STABLE) || (nxt_st == HOLD);
    core_reset_d = (nxt_st != RUN);
    ready_d      = (nxt_st == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st <= WAIT_LOCK;
      cnt    <= '0;
    end else begin
      cur_st <= nxt_st;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_run) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Outputs come straight from flops so downstream resets never see a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_reset  <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      mem_fault  <= 1'b0;
    end else begin
      mem_reset  <= mem_reset_d;
      core_reset <= core_reset_d;
      ready      <= ready_d;
      if (timeout) mem_fault <= 1'b1;
    end
  end

  assign state = cur_st;

`ifdef CORE_RESET_SEQ_LOSS_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_loss_count <= 8'd0;
    end else if (lock_loss && lock_loss_count != 8'hFF) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_reset_seq.sv
// Self-checking bench for core_reset_seq: directed table, corner sequences, randomized run vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_core_reset_seq;

  localparam int SS = 2;
  localparam int LS = 8;
  localparam int HC = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_reset;
  logic       mem_ready;
  logic       mem_reset;
  logic       core_reset;
  logic       ready;
  logic       mem_fault;
  logic [2:0] state;
`ifdef CORE_RESET_SEQ_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  always #5 clk = ~clk;

  core_reset_seq #(
    .SYNC_STAGES        (SS),
    .LOCK_STABLE_CYCLES (LS),
    .RESET_HOLD_CYCLES  (HC),
    .MEM_TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .mem_ready  (mem_ready),
    .mem_reset  (mem_reset),
    .core_reset (core_reset),
    .ready      (ready),
    .mem_fault  (mem_fault),
    .state      (state)
`ifdef CORE_RESET_SEQ_LOSS_COUNT_EN
    ,
    .lock_loss_count (lock_loss_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: phase number, time spent in the phase, dwell limits,
  // and a plain delay line standing in for the lock synchronizer.
  int m_ph;
  int m_age;
  int m_loss;
  int m_fault;
  int dwell[5];
  int lock_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_age = 0; m_loss = 0; m_fault = 0;
    lock_q.delete();
    for (int i = 0; i < SS; i++) lock_q.push_back(0);
  endtask

  task automatic model_step(input bit pll, input bit sr, input bit mr);
    int ls, nxt, fresh;
    ls = lock_q.pop_front();
    lock_q.push_back(int'(pll));
    nxt = m_ph; fresh = 0;
    if (m_ph != 0 && ls == 0) begin
      nxt = 0;
      if (m_loss < 255) m_loss++;
    end else if (sr && m_ph >= 2) begin
      nxt = 2; fresh = 1;
    end else if (m_ph == 0) begin
      if (ls != 0) nxt = 1;
    end else if (m_ph == 3 && mr) begin
      nxt = 4;
    end else if (m_ph >= 1 && m_ph <= 3 && m_age + 1 == dwell[m_ph]) begin
      if (m_ph == 3) begin nxt = 2; m_fault = 1; end
      else nxt = m_ph + 1;
    end
    m_age = (nxt != m_ph || fresh != 0) ? 0 : m_age + 1;
    m_ph  = nxt;
  endtask

  function automatic int exp_vec();
    return (m_ph << 4) | (int'(m_ph <= 2) << 3) | (int'(m_ph != 4) << 2) |
           (int'(m_ph == 4) << 1) | m_fault;
  endfunction

  function automatic int dut_vec();
    return (int'(state) << 4) | (int'(mem_reset) << 3) | (int'(core_reset) << 2) |
           (int'(ready) << 1) | int'(mem_fault);
  endfunction

  function automatic int obs4();
    return (int'(state) << 3) | (int'(mem_reset) << 2) | (int'(core_reset) << 1) | int'(ready);
  endfunction

  // One clock: drive inputs, take the edge, advance the model, compare after settling.
  task automatic step(input bit pll, input bit sr, input bit mr);
    pll_locked = pll; soft_reset = sr; mem_ready = mr;
    @(posedge clk);
    cyc++;
    model_step(pll, sr, mr);
    #1;
    check("model", dut_vec(), exp_vec());
`ifdef CORE_RESET_SEQ_LOSS_COUNT_EN
    check("model_loss_count", int'(lock_loss_count), m_loss);
`endif
    soft_reset = 1'b0;
  endtask

  // Async reset applied between edges; reset values must appear immediately.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("reset_outputs", dut_vec(), 12);
`ifdef CORE_RESET_SEQ_LOSS_COUNT_EN
    check("reset_loss_count", int'(lock_loss_count), 0);
`endif
    pll_locked = 1'b0; soft_reset = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic wait_state(input int target, input bit pll, input bit mr,
                            input int limit, output bit found);
    found = 1'b0;
    for (int k = 0; k < limit && !found; k++) begin
      step(pll, 1'b0, mr);
      if (int'(state) == target) found = 1'b1;
    end
  endtask

  typedef struct {
    int n;
    int pll;
    int sr;
    int mr;
    int st;
    int mrs;
    int crs;
    int rdy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bit saw_wait;
    bit mr_ok;
    bit done;
    int run_len;
    bit pll_r, mr_r, sr_r;

    dwell[0] = 0; dwell[1] = LS; dwell[2] = HC; dwell[3] = TO; dwell[4] = 0;
    rst = 1'b1; pll_locked = 1'b0; soft_reset = 1'b0; mem_ready = 1'b0;
    model_reset();

    // Bring-up and lock loss in RUN; each row ends at an absolute cycle.
    tbl[0]  = '{10, 0, 0, 0, 0, 1, 1, 0};  // cycle 10
    tbl[1]  = '{2,  1, 0, 0, 0, 1, 1, 0};  // 12: lock still in synchronizer
    tbl[2]  = '{1,  1, 0, 0, 1, 1, 1, 0};  // 13: STABLE
    tbl[3]  = '{7,  1, 0, 0, 1, 1, 1, 0};  // 20
    tbl[4]  = '{1,  1, 0, 0, 2, 1, 1, 0};  // 21: HOLD
    tbl[5]  = '{3,  1, 0, 0, 2, 1, 1, 0};  // 24
    tbl[6]  = '{1,  1, 0, 0, 3, 0, 1, 0};  // 25: MEM_INIT, mem_reset released
    tbl[7]  = '{3,  1, 0, 0, 3, 0, 1, 0};  // 28
    tbl[8]  = '{1,  1, 0, 1, 4, 0, 0, 1};  // 29: RUN
    tbl[9]  = '{5,  1, 0, 0, 4, 0, 0, 1};  // 34: mem_ready drop ignored
    tbl[10] = '{2,  0, 0, 0, 4, 0, 0, 1};  // 36: lock loss in flight
    tbl[11] = '{1,  0, 0, 0, 0, 1, 1, 0};  // 37: back to WAIT_LOCK

    #1;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < tbl[i].n; j++)
        step(tbl[i].pll != 0, tbl[i].sr != 0, tbl[i].mr != 0);
      check($sformatf("table_row%0d", i), obs4(),
            (tbl[i].st << 3) | (tbl[i].mrs << 2) | (tbl[i].crs << 1) | tbl[i].rdy);
    end

    // Lock glitch after 5 cycles in STABLE forces a full re-qualification.
    apply_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    check("glitch_stable_entry", int'(state), 1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    saw_wait = 1'b0; mr_ok = 1'b1; done = 1'b0; run_len = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (state == 3'd0) begin saw_wait = 1'b1; run_len = 0; end
      else if (state == 3'd1) run_len++;
      else done = 1'b1;
      if (state != 3'd2 && mem_reset != 1'b1) mr_ok = 1'b0;
    end
    check("glitch_saw_wait_lock", int'(saw_wait), 1);
    check("glitch_reached_hold", int'(done), 1);
    check("glitch_requal_cycles", run_len, LS);
    check("glitch_mem_reset_held", int'(mr_ok), 1);

    // Memory init timeout: fault after exactly TO cycles, sticky through RUN.
    apply_reset();
    wait_state(3, 1'b1, 1'b0, 40, found);
    check("timeout_reach_mem_init", int'(found), 1);
    for (int k = 0; k < TO - 1; k++) step(1'b1, 1'b0, 1'b0);
    check("timeout_before_limit", (int'(state) << 1) | int'(mem_fault), 6);
    step(1'b1, 1'b0, 1'b0);
    check("timeout_at_limit", (int'(state) << 1) | int'(mem_fault), 5);
    wait_state(4, 1'b1, 1'b1, 60, found);
    check("timeout_then_run", int'(found), 1);
    check("timeout_fault_sticky", int'(mem_fault), 1);

    // Soft reset alone in RUN, then soft reset colliding with lock loss.
    step(1'b1, 1'b1, 1'b1);
    check("soft_reset_in_run", obs4(), (2 << 3) | 6);
    wait_state(4, 1'b1, 1'b1, 60, found);
    check("soft_reset_resequence", int'(found), 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("lock_loss_beats_soft_reset", obs4(), 6);

`ifdef CORE_RESET_SEQ_LOSS_COUNT_EN
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      wait_state(1, 1'b1, 1'b0, 20, found);
      wait_state(0, 1'b0, 1'b0, 20, found);
    end
    check("loss_count_three", int'(lock_loss_count), 3);
    for (int k = 0; k < 297; k++) begin
      wait_state(1, 1'b1, 1'b0, 20, found);
      wait_state(0, 1'b0, 1'b0, 20, found);
    end
    check("loss_count_saturated", int'(lock_loss_count), 255);
    wait_state(2, 1'b1, 1'b0, 40, found);
    step(1'b1, 1'b0, 1'b0);
    apply_reset();
`endif

    // Randomized traffic against the model.
    apply_reset();
    pll_r = 1'b0; mr_r = 1'b0; sr_r = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 59) == 0) pll_r = ~pll_r;
      if ($urandom_range(0, 7) == 0) mr_r = ~mr_r;
      sr_r = !sr_r && ($urandom_range(0, 39) == 0);
      step(pll_r, sr_r, mr_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
